// File: rtl/ppu_pkg.sv
// ----------------------------------------------------------------------------
// ppu_pkg
//  Shared types for the PPU front end: the posit word type and the operation
//  encoding carried from the issue controller to the core datapath.
//  No ports (package).
// ----------------------------------------------------------------------------
package ppu_pkg;

    localparam int PPU_N = 16;

    typedef logic [PPU_N-1:0] posit_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_FMADD = 3'd4,
        OP_F2P   = 3'd5,
        OP_P2F   = 3'd6
    } op_e;

endpackage

// File: rtl/ppu_result_fifo.sv
// ----------------------------------------------------------------------------
// ppu_result_fifo
//  Pointer-based in-order result queue. The head entry is presented
//  combinationally from storage. Pushes and pops in the same cycle are both
//  honoured. clr_i empties the queue on the next edge.
//  Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous clear (drops all entries)
//   push_i, data_i  write strobe and entry
//   pop_i           remove head entry
//   data_o          head entry
//   full_o, empty_o occupancy flags
// ----------------------------------------------------------------------------
module ppu_result_fifo #(
    parameter int unsigned W     = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to distinguish full from empty.
    logic [AW:0]              wr_q, rd_q;
    logic [DEPTH-1:0][W-1:0]  mem_q;
    logic                     do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed behind the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ppu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// ppu_issue_ctrl
//  Issue/retire controller in front of the fixed-latency PPU core. Ops that
//  the conditioning stage marked special bypass the core and carry their
//  precomputed value; all ops walk a LATENCY+1 stage tracker so both kinds
//  retire into the output queue in accept order. An occupancy counter
//  covering tracker + queue grants credits, so the queue can never overflow.
//  Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   in_valid_i/in_ready_o        op request handshake
//   op_i, p1_i..p3_i, tag_i      operation, conditioned operands, tag
//   special_i, special_val_i     bypass verdict and precomputed result
//   flush_i                      drop all in-flight and queued results
//   core_valid_o, core_op_o,
//   core_p1_o..core_p3_o         registered issue to the core
//   core_result_i                core result, LATENCY cycles after issue
//   out_valid_o/out_ready_i      result handshake
//   out_result_o, out_tag_o,
//   out_special_o                head result, its tag, bypass flag
//   busy_o                       any op accepted and not yet consumed
// ----------------------------------------------------------------------------
module ppu_issue_ctrl
    import ppu_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  op_e              op_i,
    input  logic [N-1:0]     p1_i,
    input  logic [N-1:0]     p2_i,
    input  logic [N-1:0]     p3_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             special_i,
    input  logic [N-1:0]     special_val_i,
    input  logic             flush_i,
    output logic             core_valid_o,
    output op_e              core_op_o,
    output logic [N-1:0]     core_p1_o,
    output logic [N-1:0]     core_p2_o,
    output logic [N-1:0]     core_p3_o,
    input  logic [N-1:0]     core_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_special_o,
    output logic             busy_o
);

    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int FW    = TAG_W + 1 + N;

    logic [OCC_W-1:0]            occ_q, occ_d;
    logic                        accept, pop, push;
    logic [LATENCY:0]            trk_vld_q, trk_spc_q;
    logic [LATENCY:0][N-1:0]     trk_val_q;
    logic [LATENCY:0][TAG_W-1:0] trk_tag_q;
    logic                        core_valid_q;
    op_e                         core_op_q;
    logic [N-1:0]                core_p1_q, core_p2_q, core_p3_q;
    logic [N-1:0]                retire_res;
    logic [FW-1:0]               push_data, head_data;
    logic                        fifo_full, fifo_empty;

    // Credit check looks only at the registered count, so a pop never
    // reaches in_ready_o in the same cycle.
    assign in_ready_o = (occ_q < OCC_W'(OUT_DEPTH));
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign pop        = out_valid_o & out_ready_i & ~flush_i;
    assign push       = trk_vld_q[LATENCY] & ~flush_i;
    assign busy_o     = (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) occ_q <= '0;
        else         occ_q <= occ_d;
    end

    // Tracker never stalls; the data lanes load every cycle and only the
    // valid lane decides whether a stage holds a real op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk_vld_q <= '0;
            trk_spc_q <= '0;
            trk_val_q <= '0;
            trk_tag_q <= '0;
        end else begin
            trk_vld_q <= flush_i ? '0 : {trk_vld_q[LATENCY-1:0], accept};
            trk_spc_q <= {trk_spc_q[LATENCY-1:0], special_i};
            trk_val_q <= {trk_val_q[LATENCY-1:0], special_val_i};
            trk_tag_q <= {trk_tag_q[LATENCY-1:0], tag_i};
        end
    end

    // Special ops leave the core registers untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_valid_q <= 1'b0;
            core_op_q    <= OP_ADD;
            core_p1_q    <= '0;
            core_p2_q    <= '0;
            core_p3_q    <= '0;
        end else begin
            core_valid_q <= accept & ~special_i;
            if (accept && !special_i) begin
                core_op_q <= op_i;
                core_p1_q <= p1_i;
                core_p2_q <= p2_i;
                core_p3_q <= p3_i;
            end
        end
    end

    assign core_valid_o = core_valid_q;
    assign core_op_o    = core_op_q;
    assign core_p1_o    = core_p1_q;
    assign core_p2_o    = core_p2_q;
    assign core_p3_o    = core_p3_q;

    // The tail stage lines up with the core result of the same op.
    assign retire_res = trk_spc_q[LATENCY] ? trk_val_q[LATENCY] : core_result_i;
    assign push_data  = {trk_tag_q[LATENCY], trk_spc_q[LATENCY], retire_res};

    ppu_result_fifo #(
        .W     (FW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid_o                             = ~fifo_empty;
    assign {out_tag_o, out_special_o, out_result_o} = head_data;

    // Credits make a push into a full queue impossible.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(push && fifo_full));

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
module tb_ppu_issue_ctrl;
    import ppu_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_ready, special, flush;
    op_e         op;
    logic [15:0] p1, p2, p3, sval, core_result;
    logic [3:0]  tag;
    logic        core_valid, out_valid, out_ready, out_special, busy;
    op_e         core_op;
    logic [15:0] core_p1, core_p2, core_p3, out_result;
    logic [3:0]  out_tag;

    int nchk = 0;
    int nerr = 0;
    logic [15:0] prev_p1;

    ppu_issue_ctrl #(.N(16), .LATENCY(3), .OUT_DEPTH(4), .TAG_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .p1_i(p1), .p2_i(p2), .p3_i(p3), .tag_i(tag),
        .special_i(special), .special_val_i(sval), .flush_i(flush),
        .core_valid_o(core_valid), .core_op_o(core_op),
        .core_p1_o(core_p1), .core_p2_o(core_p2), .core_p3_o(core_p3),
        .core_result_i(core_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_tag_o(out_tag),
        .out_special_o(out_special), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy core: 3-cycle pipe computing p1 + (p2>>2) + p3 + op.
    logic [15:0] s1, s2, s3;
    always_ff @(posedge clk) begin
        s1 <= core_valid ? (core_p1 + (core_p2 >> 2) + core_p3 + 16'(core_op)) : 16'hDEAD;
        s2 <= s1;
        s3 <= s2;
    end
    assign core_result = s3;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        op_e         op;
        logic [15:0] p1, p2, p3;
        logic        spc;
        logic [15:0] sval;
        logic [3:0]  tag;
        logic [15:0] exp_res;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic s, input logic [15:0] v,
                         input logic [3:0] t);
        in_valid = 1'b1; op = o; p1 = a; p2 = b; p3 = c; special = s; sval = v; tag = t;
    endtask

    task automatic run_op(input vec_t v);
        out_ready = 1'b0;
        drive(v.op, v.p1, v.p2, v.p3, v.spc, v.sval, v.tag);
        chk("op_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("op_core_valid", 32'(core_valid), 32'(!v.spc));
        if (!v.spc) begin
            chk("op_core_op", 32'(core_op), 32'(v.op));
            chk("op_core_p1", 32'(core_p1), 32'(v.p1));
            chk("op_core_p3", 32'(core_p3), 32'(v.p3));
            prev_p1 = v.p1;
        end else begin
            chk("op_core_p1_hold", 32'(core_p1), 32'(prev_p1));
        end
        step(); step(); step();
        chk("op_early_valid", 32'(out_valid), 32'd0);
        chk("op_busy", 32'(busy), 32'd1);
        step();
        chk("op_out_valid", 32'(out_valid), 32'd1);
        chk("op_result", 32'(out_result), 32'(v.exp_res));
        chk("op_tag", 32'(out_tag), 32'(v.tag));
        chk("op_special", 32'(out_special), 32'(v.spc));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("op_drained", 32'(out_valid), 32'd0);
        chk("op_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int acc;
        logic saw;
        logic [15:0] exp3 [4];

        tbl[0] = '{OP_ADD,   16'h4000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 4'd5,  16'h5000};
        tbl[1] = '{OP_ADD,   16'h1111, 16'h1111, 16'h1111, 1'b1, 16'h8000, 4'd2,  16'h8000};
        tbl[2] = '{OP_MUL,   16'h1234, 16'h0100, 16'h0001, 1'b0, 16'h0000, 4'd9,  16'h1277};
        tbl[3] = '{OP_DIV,   16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'd15, 16'h0000};
        tbl[4] = '{OP_FMADD, 16'h7000, 16'h0004, 16'h0002, 1'b0, 16'h0000, 4'd10, 16'h7007};

        rst_n = 1'b0; in_valid = 1'b0; op = OP_ADD; p1 = '0; p2 = '0; p3 = '0;
        tag = '0; special = 1'b0; sval = '0; flush = 1'b0; out_ready = 1'b0;
        prev_p1 = 16'h0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_core_valid", 32'(core_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_core_p1", 32'(core_p1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single ops in isolation, including bypass and operand hold
        for (int i = 0; i < 5; i++) run_op(tbl[i]);

        // Back-to-back with special mix: tag order on consecutive cycles
        out_ready = 1'b1;
        exp3[0] = 16'h1100; exp3[1] = 16'h7FFF; exp3[2] = 16'h2011; exp3[3] = 16'h0001;
        drive(OP_ADD, 16'h1000, 16'h0400, 16'h0000, 1'b0, 16'h0000, 4'd0); step();
        drive(OP_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h7FFF, 4'd1); step();
        drive(OP_SUB, 16'h2000, 16'h0000, 16'h0010, 1'b0, 16'h0000, 4'd2); step();
        drive(OP_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 4'd3); step();
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_tag", 32'(out_tag), 32'(k));
            chk("b2b_result", 32'(out_result), 32'(exp3[k]));
            step();
        end
        chk("b2b_empty", 32'(out_valid), 32'd0);

        // Backpressure: only OUT_DEPTH ops accepted, pop frees a credit a cycle later
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(OP_ADD, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0100 + 16'(i), 4'(i));
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        step(); step(); step();
        chk("bp_head_valid", 32'(out_valid), 32'd1);
        chk("bp_head_tag", 32'(out_tag), 32'd0);
        out_ready = 1'b1;
        drive(OP_ADD, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0666, 4'd6);
        chk("bp_pop_no_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        chk("bp_head_tag1", 32'(out_tag), 32'd1);
        chk("bp_head_res1", 32'(out_result), 32'h0101);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("bp_drain_tag", 32'(out_tag), 32'(k));
            step();
        end
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);

        // Flush with 3 ops in the tracker; op offered in flush cycle is dropped
        drive(OP_ADD, 16'h0100, 16'h0, 16'h0, 1'b0, 16'h0, 4'd4); step();
        drive(OP_MUL, 16'h0200, 16'h0, 16'h0, 1'b0, 16'h0, 4'd5); step();
        drive(OP_SUB, 16'h0300, 16'h0, 16'h0, 1'b1, 16'h0333, 4'd6); step();
        drive(OP_ADD, 16'h0400, 16'h0, 16'h0, 1'b0, 16'h0, 4'd7);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_core_valid", 32'(core_valid), 32'd0);
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            saw = saw | out_valid;
            step();
        end
        chk("fl_no_output", 32'(saw), 32'd0);
        chk("fl_still_idle", 32'(busy), 32'd0);

        // Async reset with two queued results and a core issue in flight
        out_ready = 1'b0;
        drive(OP_ADD, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0AAA, 4'd1); step();
        drive(OP_ADD, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0BBB, 4'd2); step();
        in_valid = 1'b0;
        step(); step(); step();
        drive(OP_ADD, 16'hABCD, 16'h0, 16'h0, 1'b0, 16'h0, 4'd3); step();
        in_valid = 1'b0;
        chk("rs_pre_valid", 32'(out_valid), 32'd1);
        chk("rs_pre_core", 32'(core_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_core_valid", 32'(core_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_core_p1", 32'(core_p1), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        prev_p1 = 16'h0;
        run_op(tbl[0]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
